// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle shared by the EX and MEM requesters.
// master = requester side, slave = arbiter side.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int RD_W       = 5
);
    logic                  ex_valid;
    logic                  ex_ready;
    logic [RD_W-1:0]       ex_rd;
    logic [DATA_WIDTH-1:0] ex_data;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [RD_W-1:0]       mem_rd;
    logic [DATA_WIDTH-1:0] mem_data;

    modport master (
        output ex_valid, ex_rd, ex_data,
        output mem_valid, mem_rd, mem_data,
        input  ex_ready, mem_ready
    );

    modport slave (
        input  ex_valid, ex_rd, ex_data,
        input  mem_valid, mem_rd, mem_data,
        output ex_ready, mem_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single RegFile write port (EX vs MEM).
// Optional decode bypass enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH_POW  = 6,
    parameter int DATA_WIDTH      = 1 << DATA_WIDTH_POW,
    parameter int GEN_REG_COUNT   = 32,
    parameter int STALL_CNT_WIDTH = 16,
    // 5 for the default 32-entry register file
    parameter int RD_W            = $clog2(GEN_REG_COUNT)
) (
    input  logic                       clk_in,
    input  logic                       reset,
    regfile_wb_arbiter_if.slave        wb,
    output logic                       regWrite_ctrl,
    output logic [RD_W-1:0]            rd_out,
    output logic [DATA_WIDTH-1:0]      writeData_out,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [RD_W-1:0]            rs1_in,
    input  logic [RD_W-1:0]            rs2_in,
    output logic                       byp1_hit,
    output logic                       byp2_hit,
    output logic [DATA_WIDTH-1:0]      byp1_data,
    output logic [DATA_WIDTH-1:0]      byp2_data
`endif
);

    typedef enum logic {
        PRIO_EX  = 1'b0,
        PRIO_MEM = 1'b1
    } prio_e;

    prio_e prio;
    prio_e prio_nxt;

    logic                  both_valid;
    logic                  grant;
    logic                  wr_en;
    logic [RD_W-1:0]       sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  stall_evt;
    logic                  stall_sat;

    assign both_valid = wb.ex_valid && wb.mem_valid;

    // Priority pointer register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            prio <= PRIO_EX;
        end else begin
            prio <= prio_nxt;
        end
    end

    // Next priority: only contention moves the pointer, to the loser
    always_comb begin
        prio_nxt = prio;
        if (both_valid) begin
            prio_nxt = (prio == PRIO_EX) ? PRIO_MEM : PRIO_EX;
        end
    end

    // Grants: a lone requester always wins, contention goes to prio
    always_comb begin
        wb.ex_ready  = 1'b0;
        wb.mem_ready = 1'b0;
        if (!reset) begin
            wb.ex_ready  = wb.ex_valid &&
                           (!wb.mem_valid || prio == PRIO_EX);
            wb.mem_ready = wb.mem_valid &&
                           (!wb.ex_valid || prio == PRIO_MEM);
        end
    end

    // Winner mux and x0 filter feeding the write-port register
    always_comb begin
        grant    = wb.ex_ready || wb.mem_ready;
        sel_rd   = wb.ex_ready ? wb.ex_rd   : wb.mem_rd;
        sel_data = wb.ex_ready ? wb.ex_data : wb.mem_data;
        wr_en    = grant && (sel_rd != '0);
    end

    // Write-port register; x0 writes and idle cycles stage a clean zero
    always_ff @(posedge clk_in) begin
        if (reset) begin
            regWrite_ctrl <= 1'b0;
            rd_out        <= '0;
            writeData_out <= '0;
        end else if (wr_en) begin
            regWrite_ctrl <= 1'b1;
            rd_out        <= sel_rd;
            writeData_out <= sel_data;
        end else begin
            regWrite_ctrl <= 1'b0;
            rd_out        <= '0;
            writeData_out <= '0;
        end
    end

    assign stall_evt = (wb.ex_valid && !wb.ex_ready) ||
                       (wb.mem_valid && !wb.mem_ready);
    assign stall_sat = &stall_cnt;

    // Saturating count of cycles where a requester was held off
    always_ff @(posedge clk_in) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_evt && !stall_sat) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the staged write to decode before RegFile commits it
    always_comb begin
        byp1_hit  = regWrite_ctrl && (rd_out == rs1_in) &&
                    (rs1_in != '0);
        byp2_hit  = regWrite_ctrl && (rd_out == rs2_in) &&
                    (rs2_in != '0);
        byp1_data = byp1_hit ? writeData_out : '0;
        byp2_data = byp2_hit ? writeData_out : '0;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Stall counter narrowed to 4 bits so saturation is reachable.
module tb_regfile_wb_arbiter;

    localparam int DW = 64;
    localparam int SW = 4;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          regWrite_ctrl;
    logic [4:0]    rd_out;
    logic [DW-1:0] writeData_out;
    logic [SW-1:0] stall_cnt;
`ifdef REGFILE_WB_BYPASS_EN
    logic [4:0]    rs1_in;
    logic [4:0]    rs2_in;
    logic          byp1_hit;
    logic          byp2_hit;
    logic [DW-1:0] byp1_data;
    logic [DW-1:0] byp2_data;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] xreg [32];

    regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .RD_W(5)) wb ();

    regfile_wb_arbiter #(
        .DATA_WIDTH_POW (6),
        .GEN_REG_COUNT  (32),
        .STALL_CNT_WIDTH(SW)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .wb           (wb.slave),
        .regWrite_ctrl(regWrite_ctrl),
        .rd_out       (rd_out),
        .writeData_out(writeData_out),
        .stall_cnt    (stall_cnt)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .rs1_in       (rs1_in),
        .rs2_in       (rs2_in),
        .byp1_hit     (byp1_hit),
        .byp2_hit     (byp2_hit),
        .byp1_data    (byp1_data),
        .byp2_data    (byp2_data)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Register file model fed by the write port
    always @(posedge clk_in) begin
        if (regWrite_ctrl) xreg[rd_out] <= writeData_out;
    end

    task automatic chk(input string tag,
                       input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) xreg[i] = '0;
        reset         = 1'b1;
        wb.ex_valid   = 1'b1;
        wb.ex_rd      = 5'd1;
        wb.ex_data    = 64'h1;
        wb.mem_valid  = 1'b1;
        wb.mem_rd     = 5'd2;
        wb.mem_data   = 64'h2;
`ifdef REGFILE_WB_BYPASS_EN
        rs1_in = '0;
        rs2_in = '0;
`endif

        // reset held two edges with both valid
        @(negedge clk_in);
        chk("rst_ex_ready", 64'(wb.ex_ready), 64'd0);
        chk("rst_mem_ready", 64'(wb.mem_ready), 64'd0);
        @(negedge clk_in);
        chk("rst_ex_ready2", 64'(wb.ex_ready), 64'd0);
        reset        = 1'b0;
        wb.ex_valid  = 1'b0;
        wb.mem_valid = 1'b0;
        chk("rst_we", 64'(regWrite_ctrl), 64'd0);
        chk("rst_rd", 64'(rd_out), 64'd0);
        chk("rst_wd", writeData_out, 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);

        // single EX write
        wb.ex_valid = 1'b1;
        wb.ex_rd    = 5'd5;
        wb.ex_data  = 64'hDEAD_BEEF;
        #1;
        chk("ex1_ready", 64'(wb.ex_ready), 64'd1);
        chk("ex1_mem_ready", 64'(wb.mem_ready), 64'd0);
        @(negedge clk_in);
        wb.ex_valid = 1'b0;
        chk("ex1_we", 64'(regWrite_ctrl), 64'd1);
        chk("ex1_rd", 64'(rd_out), 64'd5);
        chk("ex1_wd", writeData_out, 64'hDEAD_BEEF);
        @(negedge clk_in);
        chk("ex1_we_off", 64'(regWrite_ctrl), 64'd0);
        chk("ex1_stall", 64'(stall_cnt), 64'd0);

        // contention: EX, MEM, EX, MEM
        wb.ex_valid  = 1'b1;
        wb.ex_rd     = 5'd3;
        wb.ex_data   = 64'h11;
        wb.mem_valid = 1'b1;
        wb.mem_rd    = 5'd4;
        wb.mem_data  = 64'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ex_ready", 64'(wb.ex_ready),
                (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("cont_mem_ready", 64'(wb.mem_ready),
                (i % 2 == 0) ? 64'd0 : 64'd1);
            @(negedge clk_in);
            chk("cont_we", 64'(regWrite_ctrl), 64'd1);
            chk("cont_rd", 64'(rd_out),
                (i % 2 == 0) ? 64'd3 : 64'd4);
            chk("cont_wd", writeData_out,
                (i % 2 == 0) ? 64'h11 : 64'h22);
        end
        wb.ex_valid  = 1'b0;
        wb.mem_valid = 1'b0;
        chk("cont_stall", 64'(stall_cnt), 64'd4);

        // stall counter saturates at 15
        wb.ex_valid  = 1'b1;
        wb.mem_valid = 1'b1;
        repeat (11) @(negedge clk_in);
        chk("sat_reach", 64'(stall_cnt), 64'd15);
        repeat (2) @(negedge clk_in);
        chk("sat_hold", 64'(stall_cnt), 64'd15);
        wb.ex_valid  = 1'b0;
        wb.mem_valid = 1'b0;
        @(negedge clk_in);

        // reset with a write staged and a request pending
        wb.ex_valid = 1'b1;
        wb.ex_rd    = 5'd12;
        wb.ex_data  = 64'h77;
        @(negedge clk_in);
        chk("mid_staged", 64'(regWrite_ctrl), 64'd1);
        reset      = 1'b1;
        wb.ex_rd   = 5'd13;
        #1;
        chk("mid_ready", 64'(wb.ex_ready), 64'd0);
        @(negedge clk_in);
        chk("mid_we", 64'(regWrite_ctrl), 64'd0);
        chk("mid_stall", 64'(stall_cnt), 64'd0);
        reset       = 1'b0;
        wb.ex_valid = 1'b0;

        // same rd from both, prio back at EX
        wb.ex_valid  = 1'b1;
        wb.ex_rd     = 5'd7;
        wb.ex_data   = 64'hA;
        wb.mem_valid = 1'b1;
        wb.mem_rd    = 5'd7;
        wb.mem_data  = 64'hB;
        #1;
        chk("same_ex_ready", 64'(wb.ex_ready), 64'd1);
        chk("same_mem_wait", 64'(wb.mem_ready), 64'd0);
        @(negedge clk_in);
        wb.ex_valid = 1'b0;
        chk("same_rd1", 64'(rd_out), 64'd7);
        chk("same_wd1", writeData_out, 64'hA);
        #1;
        chk("same_mem_ready", 64'(wb.mem_ready), 64'd1);
        @(negedge clk_in);
        wb.mem_valid = 1'b0;
        chk("same_x7_first", xreg[7], 64'hA);
        chk("same_rd2", 64'(rd_out), 64'd7);
        chk("same_wd2", writeData_out, 64'hB);
        @(negedge clk_in);
        chk("same_x7_final", xreg[7], 64'hB);

        // x0 write accepted and dropped
        wb.mem_valid = 1'b1;
        wb.mem_rd    = 5'd0;
        wb.mem_data  = 64'hFFFF;
        #1;
        chk("x0_ready", 64'(wb.mem_ready), 64'd1);
        @(negedge clk_in);
        wb.mem_valid = 1'b0;
        chk("x0_we", 64'(regWrite_ctrl), 64'd0);
        chk("x0_rd", 64'(rd_out), 64'd0);
        chk("x0_wd", writeData_out, 64'd0);

`ifdef REGFILE_WB_BYPASS_EN
        // bypass of the staged write
        wb.ex_valid = 1'b1;
        wb.ex_rd    = 5'd9;
        wb.ex_data  = 64'h55;
        @(negedge clk_in);
        wb.ex_valid = 1'b0;
        rs1_in = 5'd9;
        rs2_in = 5'd0;
        #1;
        chk("byp1_hit", 64'(byp1_hit), 64'd1);
        chk("byp1_data", byp1_data, 64'h55);
        chk("byp2_hit", 64'(byp2_hit), 64'd0);
        chk("byp2_data", byp2_data, 64'd0);
        @(negedge clk_in);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single RegFile write port between two writeback requesters: the execute/ALU path (EX) and the load/memory path (MEM).
- Arbitrates round-robin on contention and registers the winning write into a one-stage write-port register that drives RegFile regWrite_ctrl/rd_in/writeData_in directly.
- Drops writes to x0 and counts contention stall cycles for performance monitoring.

Parameters:
- DATA_WIDTH_POW, 6, log2 of data width.
- DATA_WIDTH, 1 << DATA_WIDTH_POW, write data width.
- GEN_REG_COUNT, 32, architectural register count; register index width fixed at 5.
- STALL_CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clk_in  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- ex_valid  input  1  EX has a writeback pending.
- ex_ready  output  1  EX writeback accepted this cycle.
- ex_rd  input  5  EX destination register.
- ex_data  input  DATA_WIDTH  EX writeback data.
- mem_valid  input  1  MEM has a writeback pending.
- mem_ready  output  1  MEM writeback accepted this cycle.
- mem_rd  input  5  MEM destination register.
- mem_data  input  DATA_WIDTH  MEM writeback data.
- regWrite_ctrl  output  1  registered write enable to RegFile.
- rd_out  output  5  registered write index to RegFile.
- writeData_out  output  DATA_WIDTH  registered write data to RegFile.
- stall_cnt  output  STALL_CNT_WIDTH  saturating count of contention-stall cycles.

Behaviour:
- Clock and reset (decided): reset reset, synchronous, active-high; clock clk_in.
- Reset values:
  - regWrite_ctrl=0, rd_out=0, writeData_out=0, stall_cnt=0.
  - Round-robin pointer prio=EX.
  - ex_ready and mem_ready forced 0 while reset is high.
- Handshake:
  - A transfer occurs on a rising edge where valid&&ready.
  - Requesters hold rd/data stable while valid&&!ready.
  - ready is combinational from both valids and prio; it never depends on the requester's own data.
- Grant rules (write stage never back-pressures):
  - Only one valid: that requester's ready=1.
  - Both valid: the requester matching prio gets ready=1, the other ready=0; prio flips to the loser at that edge.
  - Neither valid: both ready=0, prio unchanged.
  - Uncontested grants do not change prio.
- Write-port register, updated every edge:
  - Granted requester with rd!=0: regWrite_ctrl<=1, rd_out<=rd, writeData_out<=data.
  - Granted requester with rd==0: accepted (ready=1) but regWrite_ctrl<=0, rd_out<=0, writeData_out<=0.
  - No grant: regWrite_ctrl<=0, rd_out<=0, writeData_out<=0.
- Latency:
  - Request accepted at edge N gives regWrite_ctrl=1 during cycle N..N+1.
  - RegFile commits at edge N+1 and the value is readable after N+1.
  - Sustained throughput is 1 write per cycle.
- Same rd from both requesters in one cycle: winner is written first and loser the following cycle, so the final register value is the loser's data.
- stall_cnt:
  - Increments by 1 on each non-reset edge where (ex_valid&&!ex_ready)||(mem_valid&&!mem_ready).
  - Saturates at all-ones and does not wrap.
- Reset mid-operation: any staged write is discarded (regWrite_ctrl=0 the cycle after reset); no pending request is accepted while reset is high.
- rd indices are always < GEN_REG_COUNT; no range check is applied.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: adds ports rs1_in, rs2_in (input, 5), byp1_hit, byp2_hit (output, 1) and byp1_data, byp2_data (output, DATA_WIDTH).
  - bypN_hit = regWrite_ctrl && rd_out==rsN_in && rsN_in!=0; bypN_data = writeData_out when hit, else 0.
  - Purely combinational from the write-port register, letting decode forward a write not yet committed to RegFile.
- Not defined: these ports and all bypass logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles with ex_valid=mem_valid=1 -> ex_ready=mem_ready=0; regWrite_ctrl=0, rd_out=0, writeData_out=0, stall_cnt=0 after release edge.
- Single EX write: ex_valid=1, ex_rd=5, ex_data=0xDEAD_BEEF -> ex_ready=1 same cycle; next cycle regWrite_ctrl=1, rd_out=5, writeData_out=0xDEAD_BEEF; following cycle regWrite_ctrl=0.
- Contention: both valid 4 cycles, EX rd=3/data=0x11, MEM rd=4/data=0x22 -> grants alternate EX,MEM,EX,MEM; stall_cnt=4.
- Same rd: both valid, EX rd=7/data=0xA, MEM rd=7/data=0xB, from reset -> EX write first, then MEM; x7 ends at 0xB.
- x0 drop: mem_valid=1, mem_rd=0, mem_data=0xFFFF -> mem_ready=1; next cycle regWrite_ctrl=0, rd_out=0, writeData_out=0.
- Bypass (REGFILE_WB_BYPASS_EN): EX write rd=9/data=0x55 accepted; next cycle rs1_in=9, rs2_in=0 -> byp1_hit=1, byp1_data=0x55, byp2_hit=0.
